// File: rtl/ex_muldiv_unit_if.sv
// EX-stage to multiply/divide unit connection: operation request, HI/LO moves,
// and the unit's status and HI/LO register outputs.
interface ex_muldiv_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        hilo_read;
  logic        mthi;
  logic        mtlo;
  logic        busy;
  logic        done;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, rs_val, rt_val, hilo_read, mthi, mtlo,
    input  busy, done, stall, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, hilo_read, mthi, mtlo,
    output busy, done, stall, hi, lo
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit with architectural HI/LO,
// one bit per cycle, raising stall while HI/LO are not yet valid.
module ex_muldiv_unit (
  input  logic            clk,
  input  logic            reset,
  ex_muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t      state;
  state_t      state_next;
  logic [4:0]  count;
  logic [63:0] acc;
  logic [31:0] opb_mag;
  logic [31:0] rs_raw;
  logic        is_div;
  logic        is_signed;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;
  logic        done_reg;

  logic        in_signed;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_shift;
  logic [31:0] div_diff;
  logic        div_ge;
  logic [63:0] div_next;
  logic [63:0] prod;
  logic [31:0] fix_hi;
  logic [31:0] fix_lo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (count == 5'd31) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Both operations start from acc = {0, |rs|}: multiply shifts the multiplier
  // out of the low half, divide shifts the dividend into the remainder half.
  always_comb begin
    in_signed = ~bus.op[0];
    mag_a     = (in_signed && bus.rs_val[31]) ? (32'd0 - bus.rs_val) : bus.rs_val;
    mag_b     = (in_signed && bus.rt_val[31]) ? (32'd0 - bus.rt_val) : bus.rt_val;

    mul_sum   = {1'b0, acc[63:32]} + {1'b0, opb_mag};
    mul_next  = acc[0] ? {mul_sum, acc[31:1]} : {1'b0, acc[63:1]};

    div_shift = {acc[63:32], acc[31]};
    div_diff  = div_shift[31:0] - opb_mag;
    div_ge    = (div_shift >= {1'b0, opb_mag});
    div_next  = div_ge ? {div_diff, acc[30:0], 1'b1}
                       : {div_shift[31:0], acc[30:0], 1'b0};
  end

  always_comb begin
    prod   = (is_signed && (neg_a ^ neg_b)) ? (64'd0 - acc) : acc;
    fix_hi = prod[63:32];
    fix_lo = prod[31:0];
    if (is_div) begin
      if (opb_mag == 32'd0) begin
        fix_hi = rs_raw;
        fix_lo = 32'hFFFF_FFFF;
      end else begin
        fix_lo = (is_signed && (neg_a ^ neg_b)) ? (32'd0 - acc[31:0]) : acc[31:0];
        fix_hi = (is_signed && neg_a) ? (32'd0 - acc[63:32]) : acc[63:32];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count     <= 5'd0;
      acc       <= 64'd0;
      opb_mag   <= 32'd0;
      rs_raw    <= 32'd0;
      is_div    <= 1'b0;
      is_signed <= 1'b0;
      neg_a     <= 1'b0;
      neg_b     <= 1'b0;
      hi_reg    <= 32'd0;
      lo_reg    <= 32'd0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            count     <= 5'd0;
            acc       <= {32'd0, mag_a};
            opb_mag   <= mag_b;
            rs_raw    <= bus.rs_val;
            is_div    <= bus.op[1];
            is_signed <= in_signed;
            neg_a     <= in_signed & bus.rs_val[31];
            neg_b     <= in_signed & bus.rt_val[31];
          end else begin
            if (bus.mthi) hi_reg <= bus.rs_val;
            if (bus.mtlo) lo_reg <= bus.rs_val;
          end
        end
        RUN: begin
          acc   <= is_div ? div_next : mul_next;
          count <= count + 5'd1;
        end
        FIX: begin
          hi_reg   <= fix_hi;
          lo_reg   <= fix_lo;
          done_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = (state != IDLE);
  assign bus.done  = done_reg;
  assign bus.stall = bus.busy & (bus.start | bus.hilo_read | bus.mthi | bus.mtlo);
  assign bus.hi    = hi_reg;
  assign bus.lo    = lo_reg;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed corner cases plus random
// operations compared against an arithmetic reference model.
module tb_ex_muldiv_unit;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  ex_muldiv_unit_if bif ();

  ex_muldiv_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected {HI,LO} from the architectural definition using wide integer math.
  function automatic logic [63:0] refModel(input logic [1:0] op_i, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa, sb, p, q, r;
    logic [63:0] ua, ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op_i)
      2'b00: begin
        p = sa * sb;
        return p;
      end
      2'b01: return ua * ub;
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (op_i == 2'b10) begin
          q = sa / sb;
          r = sa % sb;
        end else begin
          q = longint'(ua / ub);
          r = longint'(ua % ub);
        end
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  task automatic applyStimulus(input logic [1:0] op_i, input logic [31:0] a,
                               input logic [31:0] b, input bit disturb, input string tag);
    logic [63:0] exp;
    int bad;
    exp = refModel(op_i, a, b);
    @(negedge clk);
    bif.start  = 1'b1;
    bif.op     = op_i;
    bif.rs_val = a;
    bif.rt_val = b;
    @(negedge clk);
    checkOutput({tag, "_busy_e0"}, bif.busy, 1);
    bif.start  = 1'b0;
    bif.rs_val = $urandom;
    bif.rt_val = $urandom;
    bad = 0;
    for (int i = 1; i <= 32; i++) begin
      if (disturb && i == 5) begin
        bif.start     = 1'b1;
        bif.op        = 2'b10;
        bif.rs_val    = 32'h0000_DEAD;
        bif.rt_val    = 32'h0000_0009;
        bif.hilo_read = 1'b1;
        bif.mthi      = 1'b1;
        #1;
        checkOutput({tag, "_stall_busy"}, bif.stall, 1);
      end
      if (disturb && i == 6) begin
        bif.start     = 1'b0;
        bif.hilo_read = 1'b0;
        bif.mthi      = 1'b0;
      end
      @(negedge clk);
      if (bif.busy !== 1'b1 || bif.done !== 1'b0) bad++;
    end
    checkOutput({tag, "_busy_window"}, bad, 0);
    @(negedge clk);
    checkOutput({tag, "_done_e33"}, bif.done, 1);
    checkOutput({tag, "_busy_e33"}, bif.busy, 0);
    checkOutput({tag, "_hilo"}, {bif.hi, bif.lo}, exp);
    @(negedge clk);
    checkOutput({tag, "_done_e34"}, bif.done, 0);
  endtask

  logic [1:0]  dir_op [10] = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b11, 2'b10, 2'b10, 2'b11, 2'b00, 2'b10};
  logic [31:0] dir_a  [10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFF9,
                               32'd7, 32'd7, 32'h8000_0000, 32'd5, 32'h7FFF_FFFF, 32'hFFFF_FFF6};
  logic [31:0] dir_b  [10] = '{32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'd2,
                               32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'h8000_0001, 32'd0};

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bif.start     = 1'b0;
    bif.op        = 2'b00;
    bif.rs_val    = 32'd0;
    bif.rt_val    = 32'd0;
    bif.hilo_read = 1'b0;
    bif.mthi      = 1'b0;
    bif.mtlo      = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", bif.busy, 0);
    checkOutput("reset_done", bif.done, 0);
    checkOutput("reset_hilo", {bif.hi, bif.lo}, 64'd0);
    reset = 1'b0;
    bif.hilo_read = 1'b1;
    #1;
    checkOutput("idle_stall", bif.stall, 0);
    bif.hilo_read = 1'b0;

    // Spot-check values the reference model must reproduce.
    checkOutput("model_multu", refModel(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
    checkOutput("model_div", refModel(2'b10, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);

    for (int i = 0; i < 10; i++)
      applyStimulus(dir_op[i], dir_a[i], dir_b[i], 1'b0, $sformatf("dir%0d", i));

    applyStimulus(2'b01, 32'd3, 32'd4, 1'b1, "disturb");
    checkOutput("disturb_result", {bif.hi, bif.lo}, 64'd12);

    @(negedge clk);
    bif.mthi   = 1'b1;
    bif.mtlo   = 1'b1;
    bif.rs_val = 32'h0000_1234;
    #1;
    checkOutput("mt_no_bypass", {bif.hi, bif.lo}, 64'd12);
    @(negedge clk);
    checkOutput("mt_both", {bif.hi, bif.lo}, {32'h0000_1234, 32'h0000_1234});
    bif.mthi   = 1'b0;
    bif.rs_val = 32'h0000_5678;
    @(negedge clk);
    bif.mtlo   = 1'b0;
    checkOutput("mt_lo", {bif.hi, bif.lo}, {32'h0000_1234, 32'h0000_5678});

    // start together with moves in IDLE: the moves must be dropped.
    bif.start  = 1'b1;
    bif.mthi   = 1'b1;
    bif.mtlo   = 1'b1;
    bif.op     = 2'b01;
    bif.rs_val = 32'h0000_00AA;
    bif.rt_val = 32'h0000_0003;
    @(negedge clk);
    bif.start  = 1'b0;
    bif.mthi   = 1'b0;
    bif.mtlo   = 1'b0;
    checkOutput("start_wins_busy", bif.busy, 1);
    checkOutput("start_wins_hilo", {bif.hi, bif.lo}, {32'h0000_1234, 32'h0000_5678});
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_reset_busy", bif.busy, 0);
    checkOutput("async_reset_done", bif.done, 0);
    checkOutput("async_reset_hilo", {bif.hi, bif.lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(2'b11, 32'd100, 32'd7, 1'b0, "after_reset");
    checkOutput("after_reset_val", {bif.hi, bif.lo}, {32'd2, 32'd14});

    for (int i = 0; i < 24; i++) begin
      logic [1:0]  rop;
      logic [31:0] ra, rb;
      int sel;
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) rb = 32'd0;
      else if (sel == 1) rb = 32'($urandom_range(1, 15));
      else if (sel == 2) ra = 32'($urandom_range(0, 255));
      else if (sel == 3) rb = 32'hFFFF_FFFF;
      applyStimulus(rop, ra, rb, 1'b0, $sformatf("rnd%0d", i));
    end

    $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
